alarm_keypad_lock: RTL and testbench
====================================

Name: alarm_keypad_lock

Overview:
Parametrised keypad code lock that supersedes the fixed 4-key alarm system. It takes one-hot key presses and compares a CODE_LEN-digit sequence against a programmable code. It counts failed attempts and enters an alarmed lockout after MAX_FAILS consecutive failures. It sits between the debounced keypad front-end and the door/alarm actuators.

Parameters:
NUM_KEYS, 4, number of keys; width of din.
CODE_LEN, 4, digits per code entry (>=1).
MAX_FAILS, 3, consecutive failed entries that trigger LOCKOUT (>=1).
ENTRY_TIMEOUT, 32, idle cycles inside ENTRY before the attempt is abandoned.
UNLOCK_CYCLES, 64, cycles held in UNLOCKED unless relocked earlier.
LOCKOUT_CYCLES, 16, cycles held in LOCKOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
din  in  NUM_KEYS  one-hot key press; each cycle din!=0 is one press; '0 = no key
lock  in  1  relock request; honoured in UNLOCKED only
prog_en  in  1  code write strobe; honoured in UNLOCKED only
prog_code  in  CODE_LEN*KEY_W  new code; digit i at bits [i*KEY_W +: KEY_W]
status  out  3  state encoding: IDLE=0, ENTRY=1, UNLOCKED=2, FAIL=3, LOCKOUT=4
chars  out  $clog2(CODE_LEN+1)  digits entered in the current attempt
unlock  out  1  high while UNLOCKED
alarm  out  1  high while LOCKOUT
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failed attempts

Behaviour:
- Definitions: KEY_W = max(1, $clog2(NUM_KEYS)). All outputs are registered and change only on clk edges or on rst.
- Reset: status=IDLE, chars=0, unlock=0, alarm=0, fail_cnt=0, timer=0. The stored code returns to its default, digit i = i mod NUM_KEYS (A,B,C,D for the defaults). A reset asserted mid-entry, mid-unlock or mid-lockout aborts immediately.
- Press classification: one-hot din is a valid key, with index = bit position. Multi-hot din is an invalid press: it consumes a digit slot and always counts as a mismatch.
- IDLE: a press loads chars=1 and sets mismatch = (key != code[0]), then goes to ENTRY. If CODE_LEN=1, the press resolves directly (see resolution).
- ENTRY, on each press:
  - chars increments.
  - mismatch |= (key != code[chars]).
  - The timer reloads to ENTRY_TIMEOUT.
  - The entry never short-circuits on an early wrong digit; all CODE_LEN digits are always consumed.
- ENTRY, on each din=0 cycle: the timer decrements. At 0 the FSM goes to IDLE with chars=0, and fail_cnt is unchanged (a timeout is not a failure).
- Resolution happens on the edge that samples the CODE_LEN-th press, so status is updated in the same cycle chars would reach CODE_LEN. chars goes to 0.
  - No mismatch: go to UNLOCKED, fail_cnt=0, timer=UNLOCK_CYCLES.
  - Mismatch with fail_cnt+1 < MAX_FAILS: go to FAIL, fail_cnt++.
  - Mismatch with fail_cnt+1 == MAX_FAILS: go to LOCKOUT, fail_cnt=MAX_FAILS, timer=LOCKOUT_CYCLES.
- FAIL: lasts exactly one cycle, then IDLE. Keys are ignored during that cycle.
- UNLOCKED:
  - Keys are ignored.
  - prog_en=1 latches prog_code, which is effective from the next cycle.
  - lock=1, or timer expiry, goes to IDLE.
  - If prog_en and lock are asserted together, the code is written and the block relocks.
- LOCKOUT: keys, lock and prog_en are ignored. When the timer expires, go to IDLE with fail_cnt=0.
- Timer: width $clog2(max(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES)+1). It is a down-counter that never underflows.

Decomposition:
- Package alarm_pkg holds:
  - status_e enum (3-bit, values as above)
  - KEY_W localparam function
  - default-code function
- Sub-module alarm_timer: loadable down-counter with load, load_val, dec and zero outputs, parametrised by width. It is shared by the entry-timeout, unlock and lockout timing.
- The top level holds the FSM, the code register, the digit comparator and the counters.

Test Plan:
- Defaults, presses A,B,C,D on consecutive cycles:
  - chars reads 1,2,3 after each of the first three presses.
  - status=2 and unlock=1 after the D edge, with chars=0.
  - lock=1 then returns status to 0.
- A,A,C,D: no early abort, chars reaches 3. status=3 for one cycle, then 0, and fail_cnt=1.
- Three wrong entries in a row:
  - The third resolves to status=4, alarm=1, fail_cnt=3.
  - Presses during lockout are ignored.
  - After 16 cycles the block returns to status=0 with fail_cnt=0.
- Press A, then din=0 for 32 cycles: status returns to 0, chars=0, fail_cnt unchanged.
- In UNLOCKED, pulse prog_en with code D,C,B,A, then lock:
  - Entering A,B,C,D now fails.
  - Entering D,C,B,A now unlocks.
  - After rst, A,B,C,D unlocks again.
- Entry with din=4'b0011 as the second press, and rst asserted mid-entry:
  - The multi-hot press counts as a mismatch, so the entry ends in FAIL.
  - rst clears status, chars and fail_cnt to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and elaboration-time helpers for the keypad code lock.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_FAIL     = 3'd3,
        ST_LOCKOUT  = 3'd4
    } status_e;

    // Bits needed to hold one key index; a single-key pad still needs one bit.
    function automatic int key_width(input int num_keys);
        int w;
        w = $clog2(num_keys);
        return (w < 1) ? 1 : w;
    endfunction

    // Factory code: digit i is key (i mod num_keys), i.e. A,B,C,D,...
    function automatic int default_digit(input int i, input int num_keys);
        return i % num_keys;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter that saturates at zero; shared by entry, unlock and lockout timing.
module alarm_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/alarm_keypad_lock.sv
// Keypad code lock: compares a CODE_LEN-digit one-hot key sequence with a
// programmable code, counts consecutive failures and enters a timed lockout.
module alarm_keypad_lock
    import alarm_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int ENTRY_TIMEOUT  = 32,
    parameter int UNLOCK_CYCLES  = 64,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_KEYS-1:0]                        din,
    input  logic                                       lock,
    input  logic                                       prog_en,
    input  logic [CODE_LEN*key_width(NUM_KEYS)-1:0]    prog_code,
    output logic [2:0]                                 status,
    output logic [$clog2(CODE_LEN+1)-1:0]              chars,
    output logic                                       unlock,
    output logic                                       alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]             fail_cnt
);

    localparam int KEY_W   = key_width(NUM_KEYS);
    localparam int CODE_W  = CODE_LEN * KEY_W;
    localparam int CHARS_W = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W   = $clog2(max3(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

    status_e             state_q, state_d;
    logic [CHARS_W-1:0]  chars_q, chars_d;
    logic                mismatch_q, mismatch_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic                unlock_q, unlock_d;
    logic                alarm_q, alarm_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   default_code;

    logic                pressed;
    logic                key_valid;
    logic [KEY_W-1:0]    key_idx;
    logic [CHARS_W-1:0]  slot;
    logic [KEY_W-1:0]    code_digit;
    logic                digit_bad;
    logic                mis_acc;
    logic [CHARS_W-1:0]  chars_inc;
    logic                last_digit;
    logic [FAIL_W-1:0]   fail_inc;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_dec;
    logic [TMR_W-1:0]    tmr_count;
    logic                tmr_zero;
    logic                expiring;

    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_default_code
        assign default_code[gi*KEY_W +: KEY_W] = KEY_W'(default_digit(gi, NUM_KEYS));
    end

    // Multi-hot presses still occupy a digit slot but can never match.
    always_comb begin
        pressed   = |din;
        key_valid = pressed && ((din & (din - NUM_KEYS'(1))) == '0);
        key_idx   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (din[i]) begin
                key_idx = KEY_W'(i);
            end
        end
    end

    always_comb begin
        slot       = (state_q == ST_ENTRY) ? chars_q : '0;
        code_digit = code_q[int'(slot)*KEY_W +: KEY_W];
        digit_bad  = !key_valid || (key_idx != code_digit);
        mis_acc    = ((state_q == ST_ENTRY) && mismatch_q) || digit_bad;
        chars_inc  = slot + CHARS_W'(1);
        last_digit = (chars_inc == CHARS_W'(CODE_LEN));
        fail_inc   = fail_cnt_q + FAIL_W'(1);
    end

    // Leave a timed state on the edge where the counter steps from 1 to 0.
    assign expiring = tmr_zero || (tmr_count == TMR_W'(1));

    always_comb begin
        state_d      = state_q;
        chars_d      = chars_q;
        mismatch_d   = mismatch_q;
        fail_cnt_d   = fail_cnt_q;
        code_d       = code_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (pressed) begin
                    if (last_digit) begin
                        chars_d    = '0;
                        mismatch_d = 1'b0;
                        if (!mis_acc) begin
                            state_d      = ST_UNLOCKED;
                            fail_cnt_d   = '0;
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(UNLOCK_CYCLES);
                        end else if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d      = ST_LOCKOUT;
                            fail_cnt_d   = fail_inc;
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            state_d    = ST_FAIL;
                            fail_cnt_d = fail_inc;
                        end
                    end else begin
                        state_d      = ST_ENTRY;
                        chars_d      = chars_inc;
                        mismatch_d   = mis_acc;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(ENTRY_TIMEOUT);
                    end
                end else if (state_q == ST_ENTRY) begin
                    tmr_dec = 1'b1;
                    if (expiring) begin
                        state_d    = ST_IDLE;
                        chars_d    = '0;
                        mismatch_d = 1'b0;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            ST_UNLOCKED: begin
                tmr_dec = 1'b1;
                if (prog_en) begin
                    code_d = prog_code;
                end
                if (lock || expiring) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (expiring) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                chars_d    = '0;
                mismatch_d = 1'b0;
            end
        endcase

        unlock_d = (state_d == ST_UNLOCKED);
        alarm_d  = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            chars_q    <= '0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            code_q     <= default_code;
        end else begin
            state_q    <= state_d;
            chars_q    <= chars_d;
            mismatch_q <= mismatch_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
            code_q     <= code_d;
        end
    end

    alarm_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    assign status   = state_q;
    assign chars    = chars_q;
    assign unlock   = unlock_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_alarm_keypad_lock.sv
// Directed bench for alarm_keypad_lock with default parameters.
module tb_alarm_keypad_lock;

    localparam logic [3:0] KA = 4'b0001;
    localparam logic [3:0] KB = 4'b0010;
    localparam logic [3:0] KC = 4'b0100;
    localparam logic [3:0] KD = 4'b1000;
    // Sequences: nibble 0 is the first press.
    localparam logic [15:0] SEQ_ABCD = 16'h8421;
    localparam logic [15:0] SEQ_DCBA = 16'h1248;
    localparam logic [15:0] SEQ_AAAA = 16'h1111;
    // Code words: digit i at bits [2i +: 2].
    localparam logic [7:0] CODE_DCBA = 8'b00_01_10_11;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       lock;
    logic       prog_en;
    logic [7:0] prog_code;
    logic [2:0] status;
    logic [2:0] chars;
    logic       unlock;
    logic       alarm;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    alarm_keypad_lock dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .lock      (lock),
        .prog_en   (prog_en),
        .prog_code (prog_code),
        .status    (status),
        .chars     (chars),
        .unlock    (unlock),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] k, input logic l, input logic p);
        din = k; lock = l; prog_en = p;
        @(posedge clk); #1;
        din = '0; lock = 1'b0; prog_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [15:0] seq);
        for (int i = 0; i < 4; i++) cyc(seq[i*4 +: 4], 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", status); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL reset_chars: got %0d want 0", chars); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL reset_unlock: got %0b want 0", unlock); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %0b want 0", alarm); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_unlock();
        cyc(KA, 1'b0, 1'b0);
        checks++; if (chars !== 3'd1) begin errors++; $display("FAIL unlock_chars1: got %0d want 1", chars); end
        checks++; if (status !== 3'd1) begin errors++; $display("FAIL unlock_entry_status: got %0d want 1", status); end
        cyc(KB, 1'b0, 1'b0);
        checks++; if (chars !== 3'd2) begin errors++; $display("FAIL unlock_chars2: got %0d want 2", chars); end
        cyc(KC, 1'b0, 1'b0);
        checks++; if (chars !== 3'd3) begin errors++; $display("FAIL unlock_chars3: got %0d want 3", chars); end
        cyc(KD, 1'b0, 1'b0);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL unlock_status: got %0d want 2", status); end
        checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL unlock_flag: got %0b want 1", unlock); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL unlock_chars0: got %0d want 0", chars); end
        cyc(4'b0000, 1'b1, 1'b0);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL relock_status: got %0d want 0", status); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL relock_unlock: got %0b want 0", unlock); end
        $display("test_unlock done");
    endtask

    task automatic test_fail();
        cyc(KA, 1'b0, 1'b0);
        cyc(KA, 1'b0, 1'b0);
        cyc(KC, 1'b0, 1'b0);
        checks++; if (chars !== 3'd3) begin errors++; $display("FAIL fail_no_abort_chars: got %0d want 3", chars); end
        checks++; if (status !== 3'd1) begin errors++; $display("FAIL fail_no_abort_status: got %0d want 1", status); end
        cyc(KD, 1'b0, 1'b0);
        checks++; if (status !== 3'd3) begin errors++; $display("FAIL fail_status: got %0d want 3", status); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL fail_cnt1: got %0d want 1", fail_cnt); end
        // A press during the FAIL cycle must be dropped.
        cyc(KA, 1'b0, 1'b0);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL fail_to_idle: got %0d want 0", status); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL fail_key_ignored: got %0d want 0", chars); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL fail_cnt_hold: got %0d want 1", fail_cnt); end
        $display("test_fail done");
    endtask

    task automatic test_lockout();
        enter(SEQ_ABCD);
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lock_success_clears: got %0d want 0", fail_cnt); end
        cyc(4'b0000, 1'b1, 1'b0);
        enter(SEQ_AAAA);
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL lock_first_fail: got %0d want 1", fail_cnt); end
        idle(1);
        enter(SEQ_AAAA);
        checks++; if (status !== 3'd3) begin errors++; $display("FAIL lock_second_status: got %0d want 3", status); end
        checks++; if (fail_cnt !== 2'd2) begin errors++; $display("FAIL lock_second_fail: got %0d want 2", fail_cnt); end
        idle(1);
        enter(SEQ_AAAA);
        checks++; if (status !== 3'd4) begin errors++; $display("FAIL lockout_status: got %0d want 4", status); end
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL lockout_alarm: got %0b want 1", alarm); end
        checks++; if (fail_cnt !== 2'd3) begin errors++; $display("FAIL lockout_fail_cnt: got %0d want 3", fail_cnt); end
        enter(SEQ_ABCD);
        checks++; if (status !== 3'd4) begin errors++; $display("FAIL lockout_keys_status: got %0d want 4", status); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL lockout_keys_chars: got %0d want 0", chars); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL lockout_keys_unlock: got %0b want 0", unlock); end
        idle(11);
        checks++; if (status !== 3'd4) begin errors++; $display("FAIL lockout_cycle15: got %0d want 4", status); end
        idle(1);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL lockout_exit_status: got %0d want 0", status); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL lockout_exit_alarm: got %0b want 0", alarm); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lockout_exit_fail_cnt: got %0d want 0", fail_cnt); end
        $display("test_lockout done");
    endtask

    task automatic test_timeout();
        enter(SEQ_AAAA);
        idle(1);
        cyc(KA, 1'b0, 1'b0);
        checks++; if (status !== 3'd1) begin errors++; $display("FAIL timeout_entry: got %0d want 1", status); end
        idle(31);
        checks++; if (status !== 3'd1) begin errors++; $display("FAIL timeout_cycle31_status: got %0d want 1", status); end
        checks++; if (chars !== 3'd1) begin errors++; $display("FAIL timeout_cycle31_chars: got %0d want 1", chars); end
        idle(1);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL timeout_status: got %0d want 0", status); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL timeout_chars: got %0d want 0", chars); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL timeout_fail_cnt: got %0d want 1", fail_cnt); end
        $display("test_timeout done");
    endtask

    task automatic test_prog();
        enter(SEQ_ABCD);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL prog_unlock: got %0d want 2", status); end
        prog_code = CODE_DCBA;
        cyc(4'b0000, 1'b0, 1'b1);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL prog_stay_unlocked: got %0d want 2", status); end
        cyc(4'b0000, 1'b1, 1'b0);
        enter(SEQ_ABCD);
        checks++; if (status !== 3'd3) begin errors++; $display("FAIL prog_old_code: got %0d want 3", status); end
        idle(1);
        enter(SEQ_DCBA);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL prog_new_code: got %0d want 2", status); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL prog_new_code_fail_cnt: got %0d want 0", fail_cnt); end
        // Write and relock on the same cycle: the code still lands.
        prog_code = 8'b11_10_01_00;
        cyc(4'b0000, 1'b1, 1'b1);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL prog_lock_together: got %0d want 0", status); end
        enter(SEQ_ABCD);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL prog_lock_together_code: got %0d want 2", status); end
        prog_code = CODE_DCBA;
        cyc(4'b0000, 1'b1, 1'b1);
        do_reset();
        enter(SEQ_ABCD);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL prog_reset_default: got %0d want 2", status); end
        idle(63);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL unlock_cycle64_status: got %0d want 2", status); end
        idle(1);
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL unlock_expire_status: got %0d want 0", status); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL unlock_expire_flag: got %0b want 0", unlock); end
        $display("test_prog done");
    endtask

    task automatic test_multihot_rst();
        enter(16'h8431);
        checks++; if (status !== 3'd3) begin errors++; $display("FAIL multihot_status: got %0d want 3", status); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL multihot_fail_cnt: got %0d want 1", fail_cnt); end
        idle(1);
        cyc(KA, 1'b0, 1'b0);
        cyc(KB, 1'b0, 1'b0);
        checks++; if (chars !== 3'd2) begin errors++; $display("FAIL midentry_chars: got %0d want 2", chars); end
        #2 rst = 1'b1;
        #1;
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL async_rst_status: got %0d want 0", status); end
        checks++; if (chars !== 3'd0) begin errors++; $display("FAIL async_rst_chars: got %0d want 0", chars); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL async_rst_fail_cnt: got %0d want 0", fail_cnt); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        $display("test_multihot_rst done");
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        din = '0;
        lock = 1'b0;
        prog_en = 1'b0;
        prog_code = '0;
        @(posedge clk); #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        test_unlock();
        test_fail();
        test_lockout();
        test_timeout();
        test_prog();
        test_multihot_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
